// File: rtl/serial_pattern_tx_pkg.sv
// Shared definitions for the serial pattern transmitter: FSM state type
// and default constants used by the transmitter and its users.
package serial_pattern_tx_pkg;

  // Transmitter FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // Default pattern: the "0110" sequence the downstream detector looks for
  localparam logic [3:0] DEFAULT_PAT = 4'b0110;

  // Default line level when no pattern bit is being driven
  localparam logic DEFAULT_IDLE_LVL = 1'b1;

endpackage : serial_pattern_tx_pkg

// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: accepts a pattern and a repetition count via
// valid/ready, then shifts the pattern out MSB-first one bit per clock,
// inserting GAP idle-level bits between repetitions.
module serial_pattern_tx
  import serial_pattern_tx_pkg::*;
#(
  parameter int   PAT_W    = 4,
  parameter int   CNT_W    = 4,
  parameter int   GAP      = 1,
  parameter logic IDLE_LVL = DEFAULT_IDLE_LVL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [PAT_W-1:0] load_pat,
  input  logic [CNT_W-1:0] load_reps,
  output logic             sdo,
  output logic             sdo_valid,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W = $clog2(PAT_W);
  // Gap counter holds "remaining gap cycles after the current one"; keep it
  // at least one bit wide so GAP=0/1 still elaborate cleanly.
  localparam int GAP_W = (GAP < 2) ? 1 : $clog2(GAP);

  localparam logic [IDX_W-1:0] IDX_MSB  = IDX_W'(PAT_W - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP > 0) ? GAP - 1 : 0);

  state_t             state_reg;
  logic [PAT_W-1:0]   pat_reg;
  logic [IDX_W-1:0]   bit_idx_reg;   // index of the bit currently on sdo
  logic [CNT_W-1:0]   reps_reg;      // repetitions left, including current
  logic [GAP_W-1:0]   gap_cnt_reg;   // gap cycles left after the current one

  // FSM with registered outputs; bit index, gap and repetition down-counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      pat_reg     <= '0;
      bit_idx_reg <= '0;
      reps_reg    <= '0;
      gap_cnt_reg <= '0;
      sdo         <= IDLE_LVL;
      sdo_valid   <= 1'b0;
      load_ready  <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (load_valid && load_ready) begin
            pat_reg  <= load_pat;
            reps_reg <= load_reps;
            if (load_reps != '0) begin
              state_reg   <= ST_SHIFT;
              bit_idx_reg <= IDX_MSB;
              sdo         <= load_pat[PAT_W-1];
              sdo_valid   <= 1'b1;
              busy        <= 1'b1;
              load_ready  <= 1'b0;
            end else begin
              // Empty job: acknowledge immediately, nothing is sent
              done <= 1'b1;
            end
          end
        end

        ST_SHIFT: begin
          if (bit_idx_reg != '0) begin
            bit_idx_reg <= bit_idx_reg - 1'b1;
            sdo         <= pat_reg[bit_idx_reg - 1'b1];
          end else begin
            reps_reg <= reps_reg - 1'b1;
            if (reps_reg == CNT_W'(1)) begin
              // Last bit of last repetition: no trailing gap
              state_reg  <= ST_IDLE;
              sdo        <= IDLE_LVL;
              sdo_valid  <= 1'b0;
              busy       <= 1'b0;
              load_ready <= 1'b1;
              done       <= 1'b1;
            end else if (GAP > 0) begin
              state_reg   <= ST_GAP;
              gap_cnt_reg <= GAP_LAST;
              sdo         <= IDLE_LVL;
            end else begin
              // Back-to-back repetition, no bubble
              bit_idx_reg <= IDX_MSB;
              sdo         <= pat_reg[PAT_W-1];
            end
          end
        end

        ST_GAP: begin
          if (gap_cnt_reg != '0) begin
            gap_cnt_reg <= gap_cnt_reg - 1'b1;
          end else begin
            state_reg   <= ST_SHIFT;
            bit_idx_reg <= IDX_MSB;
            sdo         <= pat_reg[PAT_W-1];
          end
        end

        default: begin
          state_reg  <= ST_IDLE;
          sdo        <= IDLE_LVL;
          sdo_valid  <= 1'b0;
          busy       <= 1'b0;
          load_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule : serial_pattern_tx
